prog_loader: RTL and testbench

//  Writer side of the program-memory interface: receives a framed byte stream and writes

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader_byte_assembler.sv | 36 +++
 rtl/prog_loader.sv | 102 ++++++++++
 tb/tb_prog_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame layout constants.
package prog_loader_pkg;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 16 / 8;

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic int bytes_per_word(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Collects bytes MSB-first into an instruction word and flags the word one cycle after its last byte.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
#(
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_en,
    output logic             last_byte,
    output logic             word_valid,
    output logic [8*BPW-1:0] word
);

    logic [7:0]         cnt;
    logic [8*BPW+7:0]   shifted;

    assign last_byte = (cnt == 8'(BPW - 1));
    assign shifted   = {word, byte_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && last_byte;
            if (byte_en) begin
                word <= shifted[8*BPW-1:0];
                cnt  <= last_byte ? 8'd0 : cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes instruction words into program memory and
// releases the CPU reset only after a complete, checksum-valid image.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               pm_we,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [INSTR_W-1:0] pm_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               err,
    output state_t             state
);

    localparam int BPW      = bytes_per_word(INSTR_W);
    localparam int HDR_BITS = 8 * HDR_LEN;
    localparam logic [HDR_BITS:0] CAPACITY = (HDR_BITS + 1)'(2 ** ADDR_W);

    state_t                state_n;
    logic [7:0]            n_hi;
    logic [HDR_BITS-1:0]   n_words;
    logic [HDR_BITS-1:0]   n_rx;
    logic [7:0]            chk_acc;
    logic [ADDR_W:0]       word_idx;
    logic                  accept;
    logic                  asm_en;
    logic                  last_byte;
    logic                  last_word;
    logic                  word_valid;
    logic [INSTR_W-1:0]    word;

    prog_loader_byte_assembler #(.BPW(BPW)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .byte_en    (asm_en),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // Ready drops while a word is being written, so at most one word is ever in flight.
    assign rx_ready  = !reset && !word_valid &&
                       (state inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CHK});
    assign accept    = rx_valid && rx_ready;
    assign asm_en    = accept && (state == S_DATA);
    assign n_rx      = {n_hi, rx_data};
    assign last_word = (HDR_BITS'(word_idx) + HDR_BITS'(1)) == n_words;

    assign pm_we     = word_valid;
    assign pm_wdata  = word;
    assign pm_addr   = word_idx[ADDR_W-1:0];
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERROR);
    assign cpu_reset = (state != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_HDR_HI;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_HDR_HI: if (accept) state_n = S_HDR_LO;
            S_HDR_LO: begin
                if (accept) begin
                    if ({1'b0, n_rx} > CAPACITY) state_n = S_ERROR;
                    else if (n_rx == '0)         state_n = S_CHK;
                    else                         state_n = S_DATA;
                end
            end
            S_DATA:   if (asm_en && last_byte && last_word) state_n = S_CHK;
            S_CHK:    if (accept) state_n = (rx_data == chk_acc) ? S_DONE : S_ERROR;
            default:  state_n = state;
        endcase
    end

    // word_idx is one bit wider than pm_addr so a full-capacity image never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_hi     <= '0;
            n_words  <= '0;
            chk_acc  <= '0;
            word_idx <= '0;
        end else begin
            if (accept && state == S_HDR_HI) n_hi <= rx_data;
            if (accept && state == S_HDR_LO) n_words <= n_rx;
            if (asm_en) chk_acc <= chk_acc ^ rx_data;
            if (word_valid) word_idx <= word_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level model builds expected writes and outcome.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 10;
    localparam int W       = ADDR_W + INSTR_W;

    logic               clk;
    logic               reset;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               pm_we;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_wdata;
    logic               cpu_reset;
    logic               done;
    logic               err;
    state_t             state;

    prog_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .pm_we     (pm_we),
        .pm_addr   (pm_addr),
        .pm_wdata  (pm_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0]  exp_q[$];
    logic [15:0]   words_q[$];
    logic [W-1:0]  cmp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // scoreboard: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && pm_we) begin
            check("rdy_low_on_we", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none", pm_addr, pm_wdata);
            end else begin
                cmp_e = exp_q.pop_front();
                check("wr_addr", 32'(pm_addr), 32'(cmp_e[W-1:INSTR_W]));
                check("wr_data", 32'(pm_wdata), 32'(cmp_e[INSTR_W-1:0]));
            end
        end
    end

    function automatic logic [7:0] model_chk();
        logic [7:0] x = 8'h00;
        foreach (words_q[i]) x = x ^ words_q[i][15:8] ^ words_q[i][7:0];
        return x;
    endfunction

    // driver
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit acc);
        repeat ($urandom_range(0, max_gap)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_pm_we", 32'(pm_we), 32'd0);
        check("rst_pm_addr", 32'(pm_addr), 32'd0);
        check("rst_pm_wdata", 32'(pm_wdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'(S_HDR_HI));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input logic [7:0] chk, input int max_gap);
        bit         acc;
        bit         ok;
        logic [7:0] b;
        send_byte(n[15:8], max_gap, acc);
        check("hdr_hi_acc", 32'(acc), 32'd1);
        if (32'(n) > (1 << ADDR_W)) begin
            send_byte(n[7:0], max_gap, acc);
            check("hdr_lo_acc", 32'(acc), 32'd1);
            check("len_err", 32'(err), 32'd1);
            check("len_cpu_reset", 32'(cpu_reset), 32'd1);
            check("len_rx_ready", 32'(rx_ready), 32'd0);
            send_byte(8'h55, 0, acc);
            check("after_err_acc", 32'(acc), 32'd0);
            check("len_done", 32'(done), 32'd0);
            return;
        end
        for (int i = 0; i < int'(n); i++) exp_q.push_back({ADDR_W'(i), words_q[i]});
        ok = (chk == model_chk());
        send_byte(n[7:0], max_gap, acc);
        check("hdr_lo_acc", 32'(acc), 32'd1);
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 2; k++) begin
                b = (k == 0) ? words_q[i][15:8] : words_q[i][7:0];
                send_byte(b, max_gap, acc);
                if (!acc) check("data_acc", 32'(acc), 32'd1);
                if (k == 1 && !pm_we) check("we_latency", 32'(pm_we), 32'd1);
            end
        end
        check("pre_chk_done", 32'(done), 32'd0);
        send_byte(chk, max_gap, acc);
        check("chk_acc", 32'(acc), 32'd1);
        check("end_done", 32'(done), 32'(ok));
        check("end_err", 32'(err), 32'(!ok));
        check("end_cpu_reset", 32'(cpu_reset), 32'(!ok));
        check("end_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        check("sticky_done", 32'(done), 32'(ok));
    endtask

    initial begin
        bit acc;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();

        // 1: good three-word image
        words_q = '{16'h1234, 16'hABCD, 16'h0001};
        check("pin_chk_t1", 32'(model_chk()), 32'h41);
        run_frame(16'd3, 8'h41, 0);

        // 2: bad checksum
        do_reset();
        run_frame(16'd3, 8'h42, 0);

        // 3: empty image
        do_reset();
        words_q = {};
        run_frame(16'd0, 8'h00, 0);

        // 4: too long
        do_reset();
        run_frame(16'h0401, 8'h00, 0);

        // 5: full capacity, word i = i
        do_reset();
        words_q = {};
        for (int i = 0; i < 1024; i++) words_q.push_back(16'(i));
        check("pin_chk_t5", 32'(model_chk()), 32'h00);
        run_frame(16'd1024, 8'h00, 0);

        // 6: test 1 with bubbles, then a reset mid-frame followed by a clean frame
        do_reset();
        words_q = '{16'h1234, 16'hABCD, 16'h0001};
        run_frame(16'd3, 8'h41, 3);
        do_reset();
        exp_q.push_back({ADDR_W'(0), 16'h1234});
        send_byte(8'h00, 2, acc);
        send_byte(8'h03, 2, acc);
        send_byte(8'h12, 2, acc);
        send_byte(8'h34, 2, acc);
        check("mid_we", 32'(pm_we), 32'd1);
        send_byte(8'hAB, 2, acc);
        check("mid_acc", 32'(acc), 32'd1);
        do_reset();
        check("mid_drained", 32'(exp_q.size()), 32'd0);
        run_frame(16'd3, 8'h41, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
